// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-through cache between picorv32 and backing memory
module dm_cache_ctrl #(
  parameter int                  ADDR_W        = 32,
  parameter int                  LINES         = 64,
  parameter logic [ADDR_W-1:0]   UNCACHED_BASE = ADDR_W'(32'h1000_0000),
  parameter int                  CNT_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic [31:0]       cpu_rdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              flush,
  input  logic              stats_clr,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {IDLE, HIT_RESP, MEM_REQ, RESP} state_t;
  state_t state, state_next;

  logic [LINES-1:0] line_valid;
  logic [TAG_W-1:0] line_tag  [LINES];
  logic [31:0]      line_data [LINES];
  logic             flush_pending;

  logic [IDX_W-1:0] cpu_idx, req_idx;
  logic [TAG_W-1:0] cpu_tag, req_tag;
  logic             cpu_cacheable, req_cacheable, req_write;
  logic             lookup_hit, accept, do_flush, mem_done, req_line_hit;
  logic             hit_inc, miss_inc;
  logic             unused_bits;

  assign cpu_idx       = cpu_addr[IDX_W+1:2];
  assign cpu_tag       = cpu_addr[ADDR_W-1:IDX_W+2];
  assign cpu_cacheable = cpu_addr < UNCACHED_BASE;
  assign lookup_hit    = cpu_cacheable && line_valid[cpu_idx] && (line_tag[cpu_idx] == cpu_tag);

  // The latched request lives in the mem_* registers for the whole transaction.
  assign req_idx       = mem_addr[IDX_W+1:2];
  assign req_tag       = mem_addr[ADDR_W-1:IDX_W+2];
  assign req_cacheable = mem_addr < UNCACHED_BASE;
  assign req_write     = |mem_wstrb;
  assign req_line_hit  = req_cacheable && line_valid[req_idx] && (line_tag[req_idx] == req_tag);

  assign accept   = (state == IDLE) && cpu_valid && !cpu_ready && !flush_pending;
  assign do_flush = (state == IDLE) && flush_pending;
  assign mem_done = (state == MEM_REQ) && mem_ready;
  assign hit_inc  = accept && (cpu_wstrb == 4'b0) && lookup_hit;
  assign miss_inc = mem_done && !req_write && req_cacheable;

  assign unused_bits = ^{cpu_addr[1:0], mem_addr[1:0]};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (accept) state_next = ((cpu_wstrb == 4'b0) && lookup_hit) ? HIT_RESP : MEM_REQ;
      HIT_RESP: state_next = IDLE;
      MEM_REQ:  if (mem_ready) state_next = RESP;
      RESP:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_ready     <= 1'b0;
      cpu_rdata     <= 32'h0;
      mem_valid     <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= 32'h0;
      mem_wstrb     <= 4'h0;
      line_valid    <= '0;
      flush_pending <= 1'b0;
    end else begin
      cpu_ready     <= (state_next == HIT_RESP) || (state_next == RESP);
      mem_valid     <= (state_next == MEM_REQ);
      flush_pending <= flush || (flush_pending && !do_flush);
      if (do_flush) line_valid <= '0;
      if (accept) begin
        mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
        mem_wdata <= cpu_wdata;
        mem_wstrb <= cpu_wstrb;
        if (lookup_hit) cpu_rdata <= line_data[cpu_idx];
      end
      if (mem_done) begin
        cpu_rdata <= mem_rdata;
        if (miss_inc) line_valid[req_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (miss_inc) begin
      line_tag[req_idx]  <= req_tag;
      line_data[req_idx] <= mem_rdata;
    end else if (mem_done && req_write && req_line_hit) begin
      for (int b = 0; b < 4; b++)
        if (mem_wstrb[b]) line_data[req_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || stats_clr) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_inc && (hit_count != {CNT_W{1'b1}}))   hit_count  <= hit_count + CNT_W'(1);
      if (miss_inc && (miss_count != {CNT_W{1'b1}})) miss_count <= miss_count + CNT_W'(1);
    end
  end
endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate cache between the picorv32 native memory port and a slower backing memory (on-chip RAM or the DDR2 bridge).
- Replaces the ad-hoc CACHE_ADDR/CACHE_DATA register scheme with transparent caching.
- Adds an uncached MMIO window, a flush mechanism and hit/miss statistics counters.

Parameters:
- ADDR_W, 32, byte address width.
- LINES, 64, number of one-word lines; power of two, minimum 2. IDX_W = log2(LINES).
- UNCACHED_BASE, 32'h1000_0000; addresses >= this bypass the cache.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_valid  in  1  CPU request valid.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- cpu_wdata  in  32  write data.
- cpu_wstrb  in  4  byte strobes; 0 = read.
- cpu_rdata  out  32  read data, valid while cpu_ready=1.
- mem_valid  out  1  backing-memory request valid.
- mem_ready  in  1  backing-memory completion.
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0]=0).
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  byte strobes.
- mem_rdata  in  32  read data, sampled when mem_ready=1.
- flush  in  1  pulse; invalidates all lines.
- stats_clr  in  1  clears both counters.
- hit_count  out  CNT_W  cacheable read hits.
- miss_count  out  CNT_W  cacheable read misses.

Behaviour:
- Address split: index = cpu_addr[IDX_W+1:2]; tag = cpu_addr[ADDR_W-1:IDX_W+2]. Each line stores a valid bit, a tag and 32 data bits.
- Reset: the following are cleared on the next clock edge, and reset overrides every other input:
  - FSM returns to IDLE.
  - cpu_ready, mem_valid, mem_wstrb, cpu_rdata, mem_addr and mem_wdata go to 0.
  - All valid bits and both counters go to 0.
  - Any pending flush is dropped.
  - A reset mid-transaction drops mem_valid on the next cycle; a late mem_ready is ignored.
- FSM states: IDLE, HIT_RESP, MEM_REQ, RESP.
- IDLE accepts a request when cpu_valid=1, cpu_ready=0 and no flush is pending. Call the accept cycle T.
- Cacheable read hit: HIT_RESP at T+1, with cpu_ready=1 and cpu_rdata = line data. hit_count increments. Returns to IDLE.
- Cacheable read miss: MEM_REQ from T+1.
  - mem_valid=1 with mem_wstrb=0, held with stable address until mem_ready is sampled at cycle M.
  - At M+1: line filled (valid=1, tag, data=mem_rdata), cpu_ready=1, cpu_rdata = captured mem_rdata. miss_count increments.
- Write (any wstrb!=0, cacheable or not): MEM_REQ from T+1 with cpu_wdata/cpu_wstrb forwarded; cpu_ready=1 at M+1.
  - On a tag hit, only the strobed bytes of the line are updated at M+1.
  - A write miss does not allocate.
  - Writes never change the counters.
- Uncached read (addr >= UNCACHED_BASE): same timing as a miss, but no fill, no lookup and no counter change.
- Request latching: address, data and strobes are latched at T. CPU-side changes after acceptance are ignored.
- cpu_ready is exactly one cycle wide. cpu_valid in the cycle cpu_ready=1 is not treated as a new request.
- Minimum latency: hit = 1 cycle; miss/write/uncached = mem latency + 1.
- Flush:
  - A flush pulse sets flush_pending in any state.
  - The first IDLE cycle with flush_pending clears all valid bits and flush_pending; no request is accepted in that cycle (a simultaneous cpu_valid is taken one cycle later).
  - A fill completing while a flush is pending is still written; the subsequent flush clears it.
- Counters saturate at all-ones, with no wrap.
  - stats_clr zeroes both counters.
  - stats_clr has priority over an increment in the same cycle.
- mem_valid is asserted only in MEM_REQ. Only one outstanding transaction is allowed.

Test Plan:
- Reset, then read 0x0000_0040 (mem returns 0xDEADBEEF after 3 cycles) -> mem_valid held 3 cycles, cpu_ready 1 cycle later with 0xDEADBEEF; miss_count=1, hit_count=0.
- Re-read 0x0000_0040 -> cpu_ready at T+1 with 0xDEADBEEF, no mem_valid; hit_count=1.
- Write 0x0000_0040, wstrb=4'b0011, wdata=0x0000_1234 -> mem write forwarded; next read hits, returning 0xDEAD1234. Write to 0x0000_0080 (miss) -> subsequent read of 0x80 misses.
- Conflict: read 0x0000_0040 then 0x0000_0140 (same index, LINES=64) then 0x0000_0040 -> three misses, miss_count=3.
- Uncached: read 0x1000_0000 twice -> both go to memory, counters unchanged. Flush asserted mid-miss -> miss completes; next read of the same address misses again.
- Reset asserted while mem_valid=1 -> mem_valid=0 and cpu_ready=0 next cycle, counters 0, previously cached address misses. With CNT_W=4, 16 hits -> hit_count stays 4'hF.
